// File: rtl/stepper_move_sequencer_if.sv
// Command channel between the host and stepper_move_sequencer.
// The host drives the command fields; the sequencer returns cmd_ready.
interface stepper_move_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_steps;
    logic        cmd_dir;
    logic [31:0] cmd_period_min;

    modport master (output cmd_valid, cmd_steps, cmd_dir, cmd_period_min, input cmd_ready);
    modport slave  (input cmd_valid, cmd_steps, cmd_dir, cmd_period_min, output cmd_ready);
endinterface

// File: rtl/stepper_move_sequencer.sv
// One stepper move per command with a symmetric trapezoidal period ramp.
// Optional macro STEP_POSITION_EN adds a signed position counter with pos_clear.
module stepper_move_sequencer #(
    parameter int unsigned START_PERIOD = 1000,
    parameter int unsigned ACCEL_DELTA  = 50,
    parameter int unsigned PULSE_WIDTH  = 10,
    parameter int unsigned DIR_SETUP    = 20
) (
    input  logic                        clk,
    input  logic                        resetb,
    stepper_move_sequencer_if.slave     cmd,
    output logic                        step,
    output logic                        dir,
    output logic                        busy,
    output logic                        done,
    output logic [31:0]                 steps_done,
    output logic [31:0]                 cur_period
`ifdef STEP_POSITION_EN
    ,
    output logic signed [31:0]          position,
    input  logic                        pos_clear
`endif
);

    localparam logic [31:0] START_P    = 32'(START_PERIOD);
    localparam logic [31:0] PULSE_W    = 32'(PULSE_WIDTH);
    localparam logic [31:0] SETUP_LAST = 32'(DIR_SETUP) - 32'd1;
    localparam logic [31:0] PMIN_FLOOR = 32'(2 * PULSE_WIDTH);

    typedef enum logic [2:0] {IDLE, SETUP, ACCEL, CRUISE, DECEL, DONE} state_t;
    typedef enum logic [1:0] {RAMP_HOLD, RAMP_UP, RAMP_TOP, RAMP_DOWN} ramp_op_t;

    state_t      state, state_nxt;
    ramp_op_t    ramp_op;
    logic        accept;
    logic        running;
    logic        period_end;
    logic        last_step;
    logic [31:0] remaining;
    logic [31:0] rem_next;
    logic [31:0] ramp_cnt;
    logic [31:0] pmin;
    logic [31:0] pcnt;
    logic        near_pmin;

    function automatic logic [31:0] clamp_pmin(input logic [31:0] req);
        if (req < PMIN_FLOOR) return PMIN_FLOOR;
        if (req > START_P)    return START_P;
        return req;
    endfunction

    function automatic logic [31:0] sat_slow_down(input logic [31:0] p);
        logic [32:0] sum;
        sum = {1'b0, p} + 33'(ACCEL_DELTA);
        return (sum > {1'b0, START_P}) ? START_P : sum[31:0];
    endfunction

    function automatic logic [31:0] sat_dec(input logic [31:0] x);
        return (x == 32'd0) ? 32'd0 : x - 32'd1;
    endfunction

    assign running    = (state == ACCEL) || (state == CRUISE) || (state == DECEL);
    assign step       = running && (pcnt < PULSE_W);
    assign period_end = running && (pcnt == cur_period - 32'd1);
    assign last_step  = (remaining == 32'd1);
    assign rem_next   = sat_dec(remaining);
    // Compare without subtracting so a small cur_period cannot wrap.
    assign near_pmin  = ({1'b0, cur_period} <= ({1'b0, pmin} + 33'(ACCEL_DELTA)));

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        ramp_op       = RAMP_HOLD;
        accept        = 1'b0;
        cmd.cmd_ready = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        case (state)
            IDLE: begin
                cmd.cmd_ready = 1'b1;
                busy          = 1'b0;
                if (cmd.cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = (cmd.cmd_steps == 32'd0) ? DONE : SETUP;
                end
            end
            SETUP: begin
                if (pcnt >= SETUP_LAST) state_nxt = ACCEL;
            end
            ACCEL: begin
                if (period_end) begin
                    if (last_step) begin
                        state_nxt = DONE;
                    end else if (rem_next <= ramp_cnt) begin
                        state_nxt = DECEL;
                        ramp_op   = RAMP_DOWN;
                    end else if (near_pmin) begin
                        state_nxt = CRUISE;
                        ramp_op   = RAMP_TOP;
                    end else begin
                        ramp_op   = RAMP_UP;
                    end
                end
            end
            CRUISE: begin
                if (period_end) begin
                    if (last_step) begin
                        state_nxt = DONE;
                    end else if (rem_next <= ramp_cnt) begin
                        state_nxt = DECEL;
                        ramp_op   = RAMP_DOWN;
                    end
                end
            end
            DECEL: begin
                if (period_end) begin
                    if (last_step) state_nxt = DONE;
                    else           ramp_op   = RAMP_DOWN;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: command latch, setup/period phase counter and ramp registers.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            remaining  <= 32'd0;
            ramp_cnt   <= 32'd0;
            pmin       <= START_P;
            pcnt       <= 32'd0;
            cur_period <= START_P;
            steps_done <= 32'd0;
            dir        <= 1'b0;
        end else if (accept) begin
            remaining  <= cmd.cmd_steps;
            dir        <= cmd.cmd_dir;
            steps_done <= 32'd0;
            ramp_cnt   <= 32'd0;
            cur_period <= START_P;
            pmin       <= clamp_pmin(cmd.cmd_period_min);
            pcnt       <= 32'd0;
        end else if (state == SETUP) begin
            pcnt <= (state_nxt == ACCEL) ? 32'd0 : pcnt + 32'd1;
        end else if (running) begin
            if (period_end) begin
                pcnt       <= 32'd0;
                steps_done <= steps_done + 32'd1;
                remaining  <= rem_next;
                case (ramp_op)
                    RAMP_UP: begin
                        cur_period <= cur_period - 32'(ACCEL_DELTA);
                        ramp_cnt   <= ramp_cnt + 32'd1;
                    end
                    RAMP_TOP: begin
                        cur_period <= pmin;
                        ramp_cnt   <= ramp_cnt + 32'd1;
                    end
                    RAMP_DOWN: begin
                        cur_period <= sat_slow_down(cur_period);
                        ramp_cnt   <= sat_dec(ramp_cnt);
                    end
                    default: ;
                endcase
            end else begin
                pcnt <= pcnt + 32'd1;
            end
        end
    end

`ifdef STEP_POSITION_EN
    // Clear wins over a step completing in the same cycle.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb)         position <= 32'sd0;
        else if (pos_clear)  position <= 32'sd0;
        else if (period_end) position <= dir ? position + 32'sd1 : position - 32'sd1;
    end
`endif

endmodule

// File: tb/tb_stepper_move_sequencer.sv
// Randomized and directed bench for stepper_move_sequencer against a period-list model.
module tb_stepper_move_sequencer;
    localparam int unsigned START_PERIOD = 1000;
    localparam int unsigned ACCEL_DELTA  = 50;
    localparam int unsigned PULSE_WIDTH  = 10;
    localparam int unsigned DIR_SETUP    = 20;
    localparam int          LIMIT        = 30000;

    logic        clk = 1'b0;
    logic        resetb = 1'b0;
    logic        step, dir, busy, done;
    logic [31:0] steps_done, cur_period;
`ifdef STEP_POSITION_EN
    logic signed [31:0] position;
    logic               pos_clear = 1'b0;
`endif

    int errors = 0;
    int checks = 0;
    int unsigned exp_q[$];

    stepper_move_sequencer_if cmd_bus();

    stepper_move_sequencer #(
        .START_PERIOD(START_PERIOD),
        .ACCEL_DELTA (ACCEL_DELTA),
        .PULSE_WIDTH (PULSE_WIDTH),
        .DIR_SETUP   (DIR_SETUP)
    ) dut (
        .clk       (clk),
        .resetb    (resetb),
        .cmd       (cmd_bus),
        .step      (step),
        .dir       (dir),
        .busy      (busy),
        .done      (done),
        .steps_done(steps_done),
        .cur_period(cur_period)
`ifdef STEP_POSITION_EN
        ,
        .position  (position),
        .pos_clear (pos_clear)
`endif
    );

    always #5 clk = ~clk;

    // Expected list of step periods for a move, from the ramp rules.
    task automatic build_model(input int unsigned n, input int unsigned pmin_req);
        int unsigned pm, p, ramp, left;
        int phase;
        exp_q.delete();
        pm = (pmin_req < 2 * PULSE_WIDTH) ? 2 * PULSE_WIDTH :
             (pmin_req > START_PERIOD) ? START_PERIOD : pmin_req;
        p = START_PERIOD;
        ramp = 0;
        phase = 0;
        for (int unsigned i = 0; i < n; i++) begin
            exp_q.push_back(p);
            left = n - 1 - i;
            if (left == 0) break;
            if (phase != 2 && left <= ramp) phase = 2;
            if (phase == 2) begin
                p = (p + ACCEL_DELTA > START_PERIOD) ? START_PERIOD : p + ACCEL_DELTA;
                if (ramp > 0) ramp--;
            end else if (phase == 0) begin
                if (p <= pm + ACCEL_DELTA) begin
                    p = pm;
                    phase = 1;
                end else begin
                    p = p - ACCEL_DELTA;
                end
                ramp++;
            end
        end
    endtask

    task automatic run_move(input int unsigned n, input logic d, input int unsigned pm,
                            input bit poke, input int clr_t, input string name);
        int t, td, hi;
        int rises[$];
        int highs[$];
        logic [31:0] cps[$];
        logic prev;
        build_model(n, pm);
        checks++;
        if (cmd_bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before_cmd: got %b want 1", name, cmd_bus.cmd_ready);
        end
        cmd_bus.cmd_valid      = 1'b1;
        cmd_bus.cmd_steps      = n;
        cmd_bus.cmd_dir        = d;
        cmd_bus.cmd_period_min = pm;
        @(negedge clk);
        cmd_bus.cmd_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || cmd_bus.cmd_ready !== 1'b0 || dir !== d) begin
            errors++;
            $display("FAIL %s accept: busy=%b ready=%b dir=%b want 1 0 %b", name, busy, cmd_bus.cmd_ready, dir, d);
        end
        t = 0; td = -1; hi = 0; prev = 1'b0;
        while (td < 0 && t < LIMIT) begin
            if (step && !prev) begin
                rises.push_back(t);
                cps.push_back(cur_period);
            end
            if (!step && prev) highs.push_back(hi);
            hi = step ? hi + 1 : 0;
            if (done) td = t;
            if (poke && t == 50) begin
                checks++;
                if (cmd_bus.cmd_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s ready_while_busy: got %b want 0", name, cmd_bus.cmd_ready);
                end
                cmd_bus.cmd_valid = 1'b1;
                cmd_bus.cmd_steps = 3;
                cmd_bus.cmd_dir   = ~d;
            end
            if (poke && t == 60) cmd_bus.cmd_valid = 1'b0;
            if (t == clr_t) begin
`ifdef STEP_POSITION_EN
                pos_clear = 1'b1;
`endif
            end
            if (t == clr_t + 1) begin
`ifdef STEP_POSITION_EN
                pos_clear = 1'b0;
                checks++;
                if (position !== 32'sd0) begin
                    errors++;
                    $display("FAIL %s clear_vs_step: position=%0d want 0", name, position);
                end
`endif
            end
            prev = step;
            if (td < 0) begin
                @(negedge clk);
                t++;
            end
        end
        checks++;
        if (td < 0) begin
            errors++;
            $display("FAIL %s timeout: no done within %0d cycles", name, LIMIT);
        end
        checks++;
        if (rises.size() != n) begin
            errors++;
            $display("FAIL %s step_count: got %0d want %0d", name, rises.size(), n);
        end
        if (n == 0) begin
            checks++;
            if (td != 0) begin
                errors++;
                $display("FAIL %s zero_done_time: got %0d want 0", name, td);
            end
        end else if (rises.size() > 0) begin
            checks++;
            if (rises[0] != DIR_SETUP) begin
                errors++;
                $display("FAIL %s dir_setup: first step at %0d want %0d", name, rises[0], DIR_SETUP);
            end
        end
        for (int k = 0; k < rises.size() && k < exp_q.size(); k++) begin
            int plen;
            plen = (k + 1 < rises.size()) ? rises[k + 1] - rises[k] : td - rises[k];
            checks++;
            if (plen != int'(exp_q[k]) || cps[k] !== exp_q[k]) begin
                errors++;
                $display("FAIL %s period[%0d]: len=%0d cur_period=%0d want %0d", name, k, plen, cps[k], exp_q[k]);
            end
            if (k < highs.size()) begin
                checks++;
                if (highs[k] != PULSE_WIDTH) begin
                    errors++;
                    $display("FAIL %s high[%0d]: got %0d want %0d", name, k, highs[k], PULSE_WIDTH);
                end
            end
        end
        checks++;
        if (steps_done !== n || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s at_done: steps_done=%0d busy=%b want %0d 1", name, steps_done, busy, n);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || cmd_bus.cmd_ready !== 1'b1 || dir !== d || steps_done !== n) begin
            errors++;
            $display("FAIL %s after_done: done=%b busy=%b ready=%b dir=%b steps_done=%0d want 0 0 1 %b %0d",
                     name, done, busy, cmd_bus.cmd_ready, dir, steps_done, d, n);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (cmd_bus.cmd_ready !== 1'b1 || step !== 1'b0 || dir !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || steps_done !== 32'd0 || cur_period !== 32'(START_PERIOD)) begin
            errors++;
            $display("FAIL reset_values: ready=%b step=%b dir=%b busy=%b done=%b sd=%0d cp=%0d",
                     cmd_bus.cmd_ready, step, dir, busy, done, steps_done, cur_period);
        end
        resetb = 1'b1;
        @(negedge clk);
        cmd_bus.cmd_valid      = 1'b1;
        cmd_bus.cmd_steps      = 10;
        cmd_bus.cmd_dir        = 1'b1;
        cmd_bus.cmd_period_min = 100;
        @(negedge clk);
        cmd_bus.cmd_valid = 1'b0;
        repeat (25) @(negedge clk);
        checks++;
        if (step !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_step: step=%b want 1", step);
        end
        resetb = 1'b0;
        #1;
        checks++;
        if (step !== 1'b0 || busy !== 1'b0 || cmd_bus.cmd_ready !== 1'b1 ||
            cur_period !== 32'(START_PERIOD) || steps_done !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_move: step=%b busy=%b ready=%b cp=%0d sd=%0d want 0 0 1 %0d 0",
                     step, busy, cmd_bus.cmd_ready, cur_period, steps_done, START_PERIOD);
        end
        repeat (2) @(negedge clk);
        resetb = 1'b1;
        @(negedge clk);
        run_move(1, 1'b1, 500, 1'b0, -10, "reset_recover");
    endtask

    task automatic test_basic_ramp();
        run_move(5, 1'b1, 900, 1'b0, -10, "ramp5");
    endtask

    task automatic test_zero_steps();
        run_move(0, 1'b1, 900, 1'b0, -10, "zero");
    endtask

    task automatic test_single_reverse();
        run_move(1, 1'b0, 300, 1'b0, -10, "single_rev");
    endtask

    task automatic test_clamp_ignore();
        run_move(100, 1'b1, 5, 1'b1, -10, "clamp100");
    endtask

    task automatic test_random();
        for (int i = 0; i < 3; i++) begin
            int unsigned n, pm;
            logic d;
            n  = $urandom_range(1, 8);
            pm = $urandom_range(0, 1200);
            d  = 1'($urandom_range(0, 1));
            run_move(n, d, pm, 1'b0, -10, "random");
        end
    endtask

    task automatic test_back_to_back();
        run_move(2, 1'b0, 950, 1'b0, -10, "b2b_a");
        run_move(0, 1'b1, 950, 1'b0, -10, "b2b_b");
    endtask

`ifdef STEP_POSITION_EN
    task automatic test_position();
        pos_clear = 1'b1;
        @(negedge clk);
        pos_clear = 1'b0;
        checks++;
        if (position !== 32'sd0) begin
            errors++;
            $display("FAIL pos_clear_idle: position=%0d want 0", position);
        end
        run_move(7, 1'b1, 20, 1'b0, -10, "pos_fwd");
        run_move(3, 1'b0, 20, 1'b0, -10, "pos_rev");
        checks++;
        if (position !== 32'sd4) begin
            errors++;
            $display("FAIL pos_net: position=%0d want 4", position);
        end
        // Period 1 runs t=20..1019, so the period end coincides with the clear at t=1019.
        run_move(3, 1'b1, 1000, 1'b0, DIR_SETUP + START_PERIOD - 1, "pos_clr");
        checks++;
        if (position !== 32'sd2) begin
            errors++;
            $display("FAIL pos_after_clear: position=%0d want 2", position);
        end
    endtask
`endif

    initial begin
        cmd_bus.cmd_valid      = 1'b0;
        cmd_bus.cmd_steps      = 32'd0;
        cmd_bus.cmd_dir        = 1'b0;
        cmd_bus.cmd_period_min = 32'd0;
        test_reset();
        test_basic_ramp();
        test_zero_steps();
        test_single_reverse();
        test_clamp_ignore();
        test_random();
        test_back_to_back();
`ifdef STEP_POSITION_EN
        test_position();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
